// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, datapath
// selects, instruction classes and opcodes, used by alu, EXT, dm and the display mux.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } class_e;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  localparam logic [2:0] EXT_I      = 3'd0;
  localparam logic [2:0] EXT_S      = 3'd1;
  localparam logic [2:0] EXT_B      = 3'd2;
  localparam logic [2:0] EXT_U      = 3'd3;
  localparam logic [2:0] EXT_J      = 3'd4;
  localparam logic [2:0] EXT_ISHAMT = 3'd5;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JAL  = 2'd2;
  localparam logic [1:0] PC_JALR = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base ALU op for an R / I-ALU funct3; sub and sra are picked out by funct7.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'd0:    r = ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_dec.sv
// Combinational RV32I decoder: instruction class, ALU op, immediate format,
// DM access type and a legality flag for the control FSM.
module mc_dec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output class_e     cls,
  output logic [4:0] alu_op,
  output logic [2:0] ext_op,
  output logic [2:0] dm_type,
  output logic       legal
);

  always_comb begin
    cls     = C_R;
    alu_op  = ALU_ADD;
    ext_op  = EXT_I;
    dm_type = DM_W;
    legal   = 1'b0;
    case (op)
      OP_R: begin
        cls    = C_R;
        alu_op = alu_from_f3(funct3);
        if (funct7 == F7_ZERO) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          legal  = 1'b1;
          alu_op = (funct3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end
      end
      OP_IMM: begin
        cls    = C_IMM;
        alu_op = alu_from_f3(funct3);
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (funct3 == 3'd1 || funct3 == 3'd5) begin
          ext_op = EXT_ISHAMT;
          if (funct7 == F7_ZERO) begin
            legal = 1'b1;
          end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
            legal  = 1'b1;
            alu_op = ALU_SRA;
          end
        end else begin
          legal = 1'b1;
        end
      end
      OP_LUI: begin
        cls    = C_IMM;
        alu_op = ALU_PASSB;
        ext_op = EXT_U;
        legal  = 1'b1;
      end
      OP_LOAD: begin
        cls   = C_LOAD;
        legal = 1'b1;
        case (funct3)
          3'd0:    dm_type = DM_B;
          3'd1:    dm_type = DM_H;
          3'd2:    dm_type = DM_W;
          3'd4:    dm_type = DM_BU;
          3'd5:    dm_type = DM_HU;
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        cls    = C_STORE;
        ext_op = EXT_S;
        legal  = 1'b1;
        case (funct3)
          3'd0:    dm_type = DM_B;
          3'd1:    dm_type = DM_H;
          3'd2:    dm_type = DM_W;
          default: legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        cls    = C_BRANCH;
        ext_op = EXT_B;
        legal  = 1'b1;
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        cls    = C_JAL;
        ext_op = EXT_J;
        legal  = 1'b1;
      end
      OP_JALR: begin
        cls   = C_JALR;
        legal = (funct3 == 3'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I control FSM: paces the datapath one state per ce step,
// gates every write strobe with ce, and reports state, trap and retired count.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ce,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_src_b,
  output logic [4:0]       alu_op,
  output logic [2:0]       ext_op,
  output logic [2:0]       dm_type,
  output logic [1:0]       wd_sel,
  output logic [2:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  class_e           cls;
  logic             legal;
  logic             taken;
  logic             retire;
  logic             step;

  mc_dec u_dec (
    .op      (op),
    .funct3  (funct3),
    .funct7  (funct7),
    .cls     (cls),
    .alu_op  (alu_op),
    .ext_op  (ext_op),
    .dm_type (dm_type),
    .legal   (legal)
  );

  // Strobes stay low while reset is held, so a reset never leaves a partial write.
  assign step = ce & rstn;

  // funct3[0] selects the inverted sense (bne / bge / bgeu).
  assign taken = (alu_op == ALU_SUB) ? (zero ^ funct3[0]) : (~zero ^ funct3[0]);

  assign retire = (state_q == S_WB) ||
                  (state_q == S_MEM && cls == C_STORE) ||
                  (state_q == S_EX && cls == C_BRANCH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IF;
      instret_q <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = legal ? S_EX : S_HALT;
      S_EX: begin
        case (cls)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        state_d = S_IF;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM:  state_d = (cls == C_LOAD) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_src    = PC_SEQ;
    case (state_q)
      S_IF: begin
        ir_write = step;
        pc_write = step;
      end
      S_EX: begin
        case (cls)
          C_BRANCH: begin
            pc_src   = PC_BR;
            pc_write = step & taken;
          end
          C_JAL: begin
            pc_src   = PC_JAL;
            pc_write = step;
          end
          C_JALR: begin
            pc_src   = PC_JALR;
            pc_write = step;
          end
          default: ;
        endcase
      end
      S_MEM:   mem_write = step & (cls == C_STORE);
      S_WB:    reg_write = step;
      default: ;
    endcase
  end

  // IR is held from IF to the next IR load, so these selects are stable EX..WB.
  assign alu_src_b = (cls != C_R) && (cls != C_BRANCH);
  assign wd_sel    = (cls == C_LOAD) ? WD_MEM :
                     (cls == C_JAL || cls == C_JALR) ? WD_PC4 : WD_ALU;
  assign state_o   = state_q;
  assign trap      = (state_q == S_HALT);
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instructions then random RV32I words, each checked
// step-by-step against a reference model of the per-class state sequence.
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LUI = 3, K_LD = 4,
                 K_ST = 5, K_BR = 6, K_JAL = 7, K_JALR = 8;

  typedef struct {
    int kind;
    int alu;
    int ext;
    int dm;
    int wd;
    int srcb;
  } ref_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             ce = 1'b0;
  logic             zero = 1'b0;
  logic [31:0]      ir = 32'h0;
  logic [6:0]       op, funct7;
  logic [2:0]       funct3;
  logic             pc_write, ir_write, reg_write, mem_write, alu_src_b, trap;
  logic [1:0]       pc_src, wd_sel;
  logic [4:0]       alu_op;
  logic [2:0]       ext_op, dm_type, state_o;
  logic [CNT_W-1:0] instret;

  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               idle = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [2:0]       exp_q[$];

  assign op     = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ce        (ce),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .zero      (zero),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .ext_op    (ext_op),
    .dm_type   (dm_type),
    .wd_sel    (wd_sel),
    .state_o   (state_o),
    .trap      (trap),
    .instret   (instret)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: instruction word -> class and expected selects (-1 = don't care)
  function automatic ref_t classify(input logic [31:0] ins);
    ref_t r;
    int   f3, f7, br_alu;
    int   alu_tab[8];
    int   ld_dm[8];
    int   st_dm[3];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    ld_dm   = '{3, 1, 0, -1, 4, 2, -1, -1};
    st_dm   = '{3, 1, 0};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    r  = '{K_ILL, -1, -1, -1, -1, -1};
    case (ins[6:0])
      7'h33: begin
        if (f7 == 0)                  r = '{K_R, alu_tab[f3], -1, -1, 0, 0};
        else if (f7 == 32 && f3 == 0) r = '{K_R, 1, -1, -1, 0, 0};
        else if (f7 == 32 && f3 == 5) r = '{K_R, 7, -1, -1, 0, 0};
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          if (f7 == 0)                  r = '{K_I, alu_tab[f3], 5, -1, 0, 1};
          else if (f7 == 32 && f3 == 5) r = '{K_I, 7, 5, -1, 0, 1};
        end else begin
          r = '{K_I, alu_tab[f3], 0, -1, 0, 1};
        end
      end
      7'h37: r = '{K_LUI, 10, 3, -1, 0, 1};
      7'h03: if (ld_dm[f3] >= 0) r = '{K_LD, 0, 0, ld_dm[f3], 1, 1};
      7'h23: if (f3 < 3) r = '{K_ST, 0, 1, st_dm[f3], -1, 1};
      7'h63: begin
        br_alu = (f3 < 2) ? 1 : (f3 < 6) ? 3 : 4;
        if (f3 != 2 && f3 != 3) r = '{K_BR, br_alu, 2, -1, -1, 0};
      end
      7'h6F: r = '{K_JAL, -1, 4, -1, 2, -1};
      7'h67: if (f3 == 0) r = '{K_JALR, 0, 0, -1, 2, 1};
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[8];
    logic [31:0] ins;
    int          sel, f7sel;
    ops   = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    ins   = $urandom;
    sel   = $urandom_range(0, 9);
    f7sel = $urandom_range(0, 9);
    if (sel < 8) ins[6:0] = ops[sel];
    if (f7sel < 5)      ins[31:25] = 7'h00;
    else if (f7sel < 8) ins[31:25] = 7'h20;
    return ins;
  endfunction

  function automatic logic pick_ce(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return ($urandom_range(0, 2) == 0) || (idle >= 6);
  endfunction

  task automatic check_step(input logic [2:0] st, input logic ce_v, input ref_t r, input bit tk);
    bit jump;
    jump = (r.kind == K_JAL) || (r.kind == K_JALR) || (r.kind == K_BR && tk);
    check("state", state_o, st);
    check("trap", trap, st == 3'd7);
    check("instret", instret, exp_instret);
    check("ir_write", ir_write, ce_v && st == 3'd0);
    check("pc_write", pc_write, ce_v && (st == 3'd0 || (st == 3'd2 && jump)));
    check("mem_write", mem_write, ce_v && st == 3'd3 && r.kind == K_ST);
    check("reg_write", reg_write, ce_v && st == 3'd4);
    if (st == 3'd0) check("pc_src_if", pc_src, 0);
    if (st == 3'd2 && r.kind == K_BR)   check("pc_src_br", pc_src, 1);
    if (st == 3'd2 && r.kind == K_JAL)  check("pc_src_jal", pc_src, 2);
    if (st == 3'd2 && r.kind == K_JALR) check("pc_src_jalr", pc_src, 3);
    if (st >= 3'd2 && st <= 3'd4) begin
      if (r.alu >= 0)  check("alu_op", alu_op, r.alu);
      if (r.ext >= 0)  check("ext_op", ext_op, r.ext);
      if (r.srcb >= 0) check("alu_src_b", alu_src_b, r.srcb);
      if (r.dm >= 0)   check("dm_type", dm_type, r.dm);
      if (st == 3'd4)  check("wd_sel", wd_sel, r.wd);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    ce   = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_trap", trap, 0);
    check("rst_instret", instret, 0);
    check("rst_strobes", {ir_write, pc_write, reg_write, mem_write}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    cyc++;
    exp_instret = '0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int ce_mode, input int ab_mode,
                           input bit abort_ex);
    ref_t        r;
    logic [2:0]  st;
    logic        ce_v, zero_v, lt_s, lt_u;
    logic [31:0] a, b;
    bit          tk;
    int          n;
    r = classify(ins);
    exp_q.delete();
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    if (r.kind != K_ILL) exp_q.push_back(3'd2);
    if (r.kind == K_LD || r.kind == K_ST) exp_q.push_back(3'd3);
    if (r.kind != K_ILL && r.kind != K_ST && r.kind != K_BR) exp_q.push_back(3'd4);
    a = $urandom;
    case (ab_mode)
      1:       b = a;
      0:       b = a ^ (32'd1 << $urandom_range(0, 31));
      default: b = $urandom;
    endcase
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (ins[14:12])
      3'd0:    begin tk = (a == b); zero_v = (a == b); end
      3'd1:    begin tk = (a != b); zero_v = (a == b); end
      3'd4:    begin tk = lt_s;     zero_v = !lt_s;    end
      3'd5:    begin tk = !lt_s;    zero_v = !lt_s;    end
      3'd6:    begin tk = lt_u;     zero_v = !lt_u;    end
      3'd7:    begin tk = !lt_u;    zero_v = !lt_u;    end
      default: begin tk = 0;        zero_v = 1'($urandom_range(0, 1)); end
    endcase
    while (exp_q.size() > 0) begin
      st   = exp_q[0];
      ce_v = pick_ce(ce_mode);
      ce   = ce_v;
      zero = zero_v;
      @(negedge clk);
      check_step(st, ce_v, r, tk);
      if (abort_ex && st == 3'd2) begin
        #1 rstn = 1'b0;
        #1;
        check("abort_state", state_o, 0);
        check("abort_mem_write", mem_write, 0);
        check("abort_instret", instret, 0);
        exp_q.delete();
        exp_instret = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc++;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ce_v) begin
        idle = 0;
        void'(exp_q.pop_front());
        if (st == 3'd0) ir = ins;
        if (exp_q.size() == 0 && r.kind != K_ILL) exp_instret++;
      end else begin
        idle++;
      end
    end
    if (r.kind == K_ILL) begin
      n = 0;
      while (n < 20) begin
        ce_v = pick_ce(ce_mode);
        ce   = ce_v;
        @(negedge clk);
        check_step(3'd7, ce_v, r, tk);
        @(posedge clk);
        #1;
        cyc++;
        if (ce_v) begin n++; idle = 0; end
        else idle++;
      end
      do_reset();
    end
  endtask

  // Stimulus and final report
  initial begin
    #2;
    do_reset();
    run_instr(32'h00500093, 0, 2, 1'b0);  // addi x1,x0,5
    run_instr(32'h00102223, 0, 2, 1'b0);  // sw x1,4(x0)
    run_instr(32'h00402103, 0, 2, 1'b0);  // lw x2,4(x0)
    run_instr(32'h00000463, 0, 1, 1'b0);  // beq taken
    run_instr(32'h00000463, 0, 0, 1'b0);  // beq not taken
    run_instr(32'h00500093, 1, 2, 1'b0);
    run_instr(32'h00102223, 1, 2, 1'b1);  // store aborted by reset in EX
    run_instr(32'h00402103, 1, 2, 1'b0);
    run_instr(32'hFFFFFFFF, 2, 2, 1'b0);  // illegal -> HALT
    for (int i = 0; i < 200; i++) begin
      run_instr(rand_instr(), ($urandom_range(0, 1) == 0) ? 0 : 2,
                $urandom_range(0, 2), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
